// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x3 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  localparam logic [3:0] ROW0 = 4'b0001;
  localparam logic [3:0] ROW1 = 4'b0010;
  localparam logic [3:0] ROW2 = 4'b0100;
  localparam logic [3:0] ROW3 = 4'b1000;

  // True when exactly one column line is active.
  function automatic logic is_onehot(input logic [2:0] cols);
    return (cols == 3'b001) || (cols == 3'b010) || (cols == 3'b100);
  endfunction

  // Row index of a one-hot row drive; anything malformed maps to the top row.
  function automatic logic [1:0] row_index(input logic [3:0] row_onehot);
    logic [1:0] idx;
    idx = 2'd0;
    case (row_onehot)
      ROW1:    idx = 2'd1;
      ROW2:    idx = 2'd2;
      ROW3:    idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Next row in the scan order, top to bottom and back to the top.
  function automatic logic [3:0] next_row(input logic [3:0] row_onehot);
    return {row_onehot[2:0], row_onehot[3]};
  endfunction

  // Key code for a (row, column) position. Rows 0-2 hold digits 1-9 laid out
  // left to right; the bottom row is '*', '0', '#'.
  function automatic logic [3:0] key_lookup(input logic [1:0] row_idx,
                                            input logic [2:0] col_onehot);
    logic [3:0] col_idx;
    logic [3:0] code;
    col_idx = 4'd0;
    code    = 4'd0;
    case (col_onehot)
      3'b001:  col_idx = 4'd0;
      3'b010:  col_idx = 4'd1;
      3'b100:  col_idx = 4'd2;
      default: col_idx = 4'd0;
    endcase
    if (row_idx == 2'd3) begin
      case (col_idx)
        4'd0:    code = KEY_STAR;
        4'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = ({2'b00, row_idx} * 4'd3) + col_idx + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchronizer for slow asynchronous inputs such as keypad columns.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             init,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop absorbs metastability, second presents a settled value.
  always_ff @(posedge clk) begin
    if (init) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning, debouncing sequencer for the 4x3 safe keypad. Emits one
// key_valid pulse per physical press and tracks the held state until release.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 1000000,
  parameter int DEBOUNCE_TICKS = 200000
) (
  input  logic       clk,
  input  logic       init,
  input  logic [2:0] col,
  output logic [3:0] row,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int TICK_W = $clog2(SCAN_TICKS);
  localparam int DEB_W  = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(SCAN_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_SETTLE = TICK_W'(2);
  localparam logic [DEB_W-1:0]  DEB_LAST    = DEB_W'(DEBOUNCE_TICKS - 1);

  state_t            state;
  logic [TICK_W-1:0] tick_cnt;
  logic [DEB_W-1:0]  deb_cnt;
  logic [2:0]        col_s;
  logic [2:0]        latched_col;
  logic [1:0]        latched_row;

  sync_2ff #(
    .WIDTH(3)
  ) u_col_sync (
    .clk  (clk),
    .init (init),
    .d    (col),
    .q    (col_s)
  );

  // Scan/debounce/hold/release sequencer; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (init) begin
      state       <= SCAN;
      tick_cnt    <= '0;
      deb_cnt     <= '0;
      latched_col <= 3'b000;
      latched_row <= 2'd0;
      row         <= ROW0;
      key_valid   <= 1'b0;
      key_code    <= 4'd0;
      key_held    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      unique case (state)
        SCAN: begin
          if ((tick_cnt >= TICK_SETTLE) && is_onehot(col_s)) begin
            latched_col <= col_s;
            latched_row <= row_index(row);
            deb_cnt     <= '0;
            tick_cnt    <= '0;
            state       <= DEBOUNCE;
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            row      <= next_row(row);
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end

        DEBOUNCE: begin
          if (col_s != latched_col) begin
            deb_cnt  <= '0;
            tick_cnt <= '0;
            state    <= SCAN;
          end else if (deb_cnt == DEB_LAST) begin
            deb_cnt   <= '0;
            key_valid <= 1'b1;
            key_code  <= key_lookup(latched_row, latched_col);
            key_held  <= 1'b1;
            state     <= PRESSED;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end

        PRESSED: begin
          if (col_s == 3'b000) begin
            deb_cnt <= '0;
            state   <= RELEASE;
          end
        end

        RELEASE: begin
          if (col_s != 3'b000) begin
            deb_cnt <= '0;
            state   <= PRESSED;
          end else if (deb_cnt == DEB_LAST) begin
            deb_cnt  <= '0;
            tick_cnt <= '0;
            key_held <= 1'b0;
            row      <= next_row(row);
            state    <= SCAN;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end

        default: begin
          deb_cnt  <= '0;
          tick_cnt <= '0;
          state    <= SCAN;
        end
      endcase
    end
  end

endmodule
